// File: rtl/sha_msg_padder_if.sv
// Byte-stream input and padded-block output bundle of the SHA-256 message padder.
// The padder sits on the master modport; the byte source / block sink sits on slave.
interface sha_msg_padder_if #(
  parameter int MSG_SIZ = 512
);
  logic [7:0]         i_byte;
  logic               i_byte_vld;
  logic               i_last;
  logic               o_byte_rdy;
  logic [MSG_SIZ-1:0] o_msg;
  logic               o_msg_vld;
  logic               o_last_blk;
  logic               i_msg_rdy;
  logic               o_done;

  // Both streams: a transfer happens on the rising edge where valid and ready are
  // both high; the producer holds valid and data stable until that edge, and the
  // padder's ready outputs depend only on its registered state, never on valid.
  modport master (
    input  i_byte, i_byte_vld, i_last, i_msg_rdy,
    output o_byte_rdy, o_msg, o_msg_vld, o_last_blk, o_done
  );

  modport slave (
    output i_byte, i_byte_vld, i_last, i_msg_rdy,
    input  o_byte_rdy, o_msg, o_msg_vld, o_last_blk, o_done
  );
endinterface

// File: rtl/sha_msg_padder.sv
// SHA-256 front-end padder: packs message bytes into 512-bit blocks, appends 0x80,
// zero fill and the 64-bit big-endian bit length. Optional block index: SHA_PAD_BLKCNT_EN.
module sha_msg_padder #(
  parameter int MSG_SIZ = 512,
  parameter int LEN_W   = 64
) (
  input  logic              clk,
  input  logic              reset,
  sha_msg_padder_if.master  io_bus,
  output logic [1:0]        o_dbg_state
`ifdef SHA_PAD_BLKCNT_EN
  ,
  output logic [7:0]        o_blk_cnt
`endif
);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_PAD  = 2'd1,
    S_LEN  = 2'd2,
    S_EMIT = 2'd3
  } state_t;

  localparam int BUF_MSB = MSG_SIZ - 1;

  state_t             r_state;
  state_t             w_nxt_state;
  logic [MSG_SIZ-1:0] r_buf;
  logic [6:0]         r_idx;
  logic [LEN_W-1:0]   r_bitlen;
  logic               r_pad_pend;
  logic               r_len_pend;
  logic               r_final;
  logic               r_done;

  logic               w_byte_rdy;
  logic               w_msg_vld;
  logic               w_take;
  logic               w_pad_wr;
  logic               w_len_wr;
  logic               w_blk_acc;
  logic [8:0]         w_wr_pos;
  logic [63:0]        w_len_fld;

  // Byte k of the block lives at bits [511-8k -: 8].
  assign w_wr_pos  = 9'(BUF_MSB) - {r_idx[5:0], 3'b000};
  assign w_len_fld = 64'(r_bitlen);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    unique case (r_state)
      S_FILL: begin
        if (io_bus.i_byte_vld) begin
          if (r_idx == 7'd63) begin
            w_nxt_state = S_EMIT;
          end else if (io_bus.i_last) begin
            w_nxt_state = S_PAD;
          end
        end
      end
      // Room for the length field only when the 0x80 lands at byte 55 or earlier.
      S_PAD:  w_nxt_state = (r_idx <= 7'd55) ? S_LEN : S_EMIT;
      S_LEN:  w_nxt_state = S_EMIT;
      S_EMIT: begin
        if (io_bus.i_msg_rdy) begin
          if (r_final) begin
            w_nxt_state = S_FILL;
          end else if (r_pad_pend) begin
            w_nxt_state = S_PAD;
          end else if (r_len_pend) begin
            w_nxt_state = S_LEN;
          end else begin
            w_nxt_state = S_FILL;
          end
        end
      end
      default: w_nxt_state = S_FILL;
    endcase
  end

  always_comb begin
    w_byte_rdy = 1'b0;
    w_msg_vld  = 1'b0;
    w_take     = 1'b0;
    w_pad_wr   = 1'b0;
    w_len_wr   = 1'b0;
    w_blk_acc  = 1'b0;
    unique case (r_state)
      S_FILL: begin
        w_byte_rdy = 1'b1;
        w_take     = io_bus.i_byte_vld;
      end
      S_PAD:  w_pad_wr = 1'b1;
      S_LEN:  w_len_wr = 1'b1;
      S_EMIT: begin
        w_msg_vld = 1'b1;
        w_blk_acc = io_bus.i_msg_rdy;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf      <= '0;
      r_idx      <= '0;
      r_bitlen   <= '0;
      r_pad_pend <= 1'b0;
      r_len_pend <= 1'b0;
      r_final    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_blk_acc && r_final;
      if (w_take) begin
        r_buf[w_wr_pos -: 8] <= io_bus.i_byte;
        r_idx                <= r_idx + 7'd1;
        r_bitlen             <= r_bitlen + LEN_W'(8);
        if (io_bus.i_last && (r_idx == 7'd63)) begin
          r_pad_pend <= 1'b1;
        end
      end
      if (w_pad_wr) begin
        r_buf[w_wr_pos -: 8] <= 8'h80;
        r_idx                <= r_idx + 7'd1;
        if (r_idx > 7'd55) begin
          r_len_pend <= 1'b1;
        end
      end
      if (w_len_wr) begin
        r_buf[63:0] <= w_len_fld;
        r_final     <= 1'b1;
      end
      // The next block always starts from an all-zero buffer, so padding never clears bytes.
      if (w_blk_acc) begin
        r_buf <= '0;
        r_idx <= '0;
        if (r_final) begin
          r_bitlen   <= '0;
          r_final    <= 1'b0;
          r_pad_pend <= 1'b0;
          r_len_pend <= 1'b0;
        end else if (r_pad_pend) begin
          r_pad_pend <= 1'b0;
        end else if (r_len_pend) begin
          r_len_pend <= 1'b0;
        end
      end
    end
  end

`ifdef SHA_PAD_BLKCNT_EN
  logic [7:0] r_blk_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_blk_cnt <= '0;
    end else if (w_blk_acc) begin
      if (r_final) begin
        r_blk_cnt <= '0;
      end else if (r_blk_cnt != 8'hFF) begin
        r_blk_cnt <= r_blk_cnt + 8'd1;
      end
    end
  end

  assign o_blk_cnt = r_blk_cnt;
`endif

  assign io_bus.o_byte_rdy = w_byte_rdy;
  assign io_bus.o_msg_vld  = w_msg_vld;
  assign io_bus.o_last_blk = w_msg_vld & r_final;
  assign io_bus.o_msg      = r_buf;
  assign io_bus.o_done     = r_done;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_sha_msg_padder.sv
// Self-checking bench for sha_msg_padder: random messages against a byte-level
// padding model, plus the fixed "abc", boundary, backpressure and reset scenarios.
module tb_sha_msg_padder;
  localparam int W = 512;
  localparam logic [W-1:0] ABC_BLK = {32'h61626380, 416'h0, 64'h18};

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;
`ifdef SHA_PAD_BLKCNT_EN
  logic [7:0] blk_cnt;
`endif

  sha_msg_padder_if #(.MSG_SIZ(W)) bus ();

  sha_msg_padder #(.MSG_SIZ(W), .LEN_W(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .io_bus      (bus),
    .o_dbg_state (dbg_state)
`ifdef SHA_PAD_BLKCNT_EN
    ,
    .o_blk_cnt   (blk_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_last_q[$];
  int           exp_cnt_q[$];
  logic [W-1:0] got_q[$];
  logic         got_last_q[$];
  int           got_cnt_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- sink ready driver and block monitor ----------------
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       bus.i_msg_rdy = 1'b1;
      1:       bus.i_msg_rdy = 1'($urandom_range(0, 1));
      default: bus.i_msg_rdy = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!reset && bus.o_msg_vld && bus.i_msg_rdy) begin
      got_q.push_back(bus.o_msg);
      got_last_q.push_back(bus.o_last_blk);
`ifdef SHA_PAD_BLKCNT_EN
      got_cnt_q.push_back(int'(blk_cnt));
`endif
    end
  end

  // ---------------- reference model ----------------
  task automatic model_msg(input logic [7:0] msg[$]);
    logic [7:0]   p[$];
    logic [63:0]  bits;
    logic [W-1:0] blk;
    int           nblk;
    p = msg;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    bits = 64'(msg.size()) * 64'd8;
    for (int b = 7; b >= 0; b--) p.push_back(bits[8*b +: 8]);
    nblk = p.size() / 64;
    for (int c = 0; c < nblk; c++) begin
      for (int k = 0; k < 64; k++) blk[W-1-8*k -: 8] = p[64*c + k];
      exp_q.push_back(blk);
      exp_last_q.push_back(c == nblk - 1);
      exp_cnt_q.push_back((c > 255) ? 255 : c);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_msg(input logic [7:0] msg[$], input bit gaps, input bit with_last);
    int i = 0;
    int guard = 0;
    while (i < msg.size()) begin
      guard++;
      if (guard > 20000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout got %0d bytes accepted need %0d", i, msg.size());
        break;
      end
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        bus.i_byte_vld = 1'b0;
        bus.i_last     = 1'($urandom_range(0, 1));
        bus.i_byte     = 8'($urandom);
        @(posedge clk);
        #1;
        continue;
      end
      bus.i_byte     = msg[i];
      bus.i_byte_vld = 1'b1;
      bus.i_last     = with_last && (i == msg.size() - 1);
      @(negedge clk);
      if (bus.o_byte_rdy) i++;
      @(posedge clk);
      #1;
    end
    bus.i_byte_vld = 1'b0;
    bus.i_last     = 1'b0;
  endtask

  task automatic wait_blocks(input int n, output bit ok);
    int t = 0;
    while ((got_q.size() < n) && (t < 5000)) begin
      @(posedge clk);
      t++;
    end
    ok = (got_q.size() >= n);
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic void clear_queues();
    exp_q.delete(); exp_last_q.delete(); exp_cnt_q.delete();
    got_q.delete(); got_last_q.delete(); got_cnt_q.delete();
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset(3);
    @(negedge clk);
    checks++;
    if (bus.o_msg !== '0) begin errors++; $display("FAIL reset_msg got %h want 0", bus.o_msg); end
    checks++;
    if (bus.o_msg_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", bus.o_msg_vld); end
    checks++;
    if (bus.o_last_blk !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", bus.o_last_blk); end
    checks++;
    if (bus.o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.o_done); end
    checks++;
    if (bus.o_byte_rdy !== 1'b1) begin errors++; $display("FAIL reset_byte_rdy got %b want 1", bus.o_byte_rdy); end
`ifdef SHA_PAD_BLKCNT_EN
    checks++;
    if (blk_cnt !== 8'd0) begin errors++; $display("FAIL reset_blk_cnt got %0d want 0", blk_cnt); end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_abc();
    logic [7:0] msg[$];
    logic [4:0] vld_hist;
    logic [4:0] done_hist;
    bit ok;
    clear_queues();
    rdy_mode = 0;
    msg = '{8'h61, 8'h62, 8'h63};
    send_msg(msg, 1'b0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vld_hist[c]  = bus.o_msg_vld;
      done_hist[c] = bus.o_done;
    end
    checks++;
    if (vld_hist !== 5'b00100) begin errors++; $display("FAIL abc_latency vld history got %b want 00100", vld_hist); end
    checks++;
    if (done_hist !== 5'b01000) begin errors++; $display("FAIL abc_done history got %b want 01000", done_hist); end
    wait_blocks(1, ok);
    checks++;
    if (!ok || got_q.size() != 1) begin
      errors++; $display("FAIL abc_count got %0d blocks want 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== ABC_BLK) begin errors++; $display("FAIL abc_block got %h want %h", got_q[0], ABC_BLK); end
      checks++;
      if (got_last_q[0] !== 1'b1) begin errors++; $display("FAIL abc_last got %b want 1", got_last_q[0]); end
    end
    clear_queues();
  endtask

  task automatic test_boundaries();
    int lens[3] = '{55, 56, 64};
    int nblk[3] = '{1, 2, 2};
    logic [7:0] msg[$];
    bit ok;
    rdy_mode = 0;
    foreach (lens[n]) begin
      clear_queues();
      msg.delete();
      for (int i = 0; i < lens[n]; i++) msg.push_back(8'h61);
      model_msg(msg);
      send_msg(msg, 1'b0, 1'b1);
      wait_blocks(nblk[n], ok);
      checks++;
      if (got_q.size() != nblk[n]) begin
        errors++; $display("FAIL bnd%0d_count got %0d want %0d", lens[n], got_q.size(), nblk[n]);
      end else begin
        checks++;
        if (got_q[$][63:0] !== 64'(lens[n] * 8)) begin
          errors++; $display("FAIL bnd%0d_len got %h want %h", lens[n], got_q[$][63:0], 64'(lens[n] * 8));
        end
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
        logic [W-1:0] e, g;
        logic el, gl;
        e = exp_q.pop_front(); g = got_q.pop_front();
        el = exp_last_q.pop_front(); gl = got_last_q.pop_front();
        checks++;
        if (g !== e) begin errors++; $display("FAIL bnd%0d_block got %h want %h", lens[n], g, e); end
        checks++;
        if (gl !== el) begin errors++; $display("FAIL bnd%0d_last got %b want %b", lens[n], gl, el); end
      end
    end
    clear_queues();
  endtask

  task automatic test_backpressure();
    logic [7:0] msg[$];
    bit ok;
    clear_queues();
    rdy_mode = 2;
    for (int i = 0; i < 70; i++) msg.push_back(8'($urandom));
    model_msg(msg);
    fork
      send_msg(msg, 1'b0, 1'b1);
      begin
        logic [W-1:0] snap;
        logic [1:0]   snap_st;
        int t = 0;
        while (!bus.o_msg_vld && t < 500) begin
          @(negedge clk);
          t++;
        end
        checks++;
        if (bus.o_msg_vld !== 1'b1) begin errors++; $display("FAIL bp_vld_seen got %b want 1", bus.o_msg_vld); end
        snap = bus.o_msg;
        snap_st = dbg_state;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          checks++;
          if (bus.o_msg !== snap || bus.o_msg_vld !== 1'b1 || bus.o_byte_rdy !== 1'b0 || dbg_state !== snap_st) begin
            errors++;
            $display("FAIL bp_stall cyc %0d got vld %b rdy %b st %0d msg_stable %0b want vld 1 rdy 0 st %0d stable 1",
                     c, bus.o_msg_vld, bus.o_byte_rdy, dbg_state, bus.o_msg === snap, snap_st);
          end
        end
        @(posedge clk);
        #1;
        rdy_mode = 0;
      end
    join
    wait_blocks(exp_q.size(), ok);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL bp_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [W-1:0] e, g;
      logic el, gl;
      e = exp_q.pop_front(); g = got_q.pop_front();
      el = exp_last_q.pop_front(); gl = got_last_q.pop_front();
      checks++;
      if (g !== e || gl !== el) begin
        errors++; $display("FAIL bp_block got %h last %b want %h last %b", g, gl, e, el);
      end
    end
    clear_queues();
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg[$];
    bit ok;
    clear_queues();
    rdy_mode = 1;
    for (int m = 0; m < 6; m++) begin
      int len;
      len = (m == 0) ? 1 : $urandom_range(1, 200);
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      model_msg(msg);
      send_msg(msg, 1'b1, 1'b1);
    end
    wait_blocks(exp_q.size(), ok);
    rdy_mode = 0;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [W-1:0] e, g;
      logic el, gl;
      int ec;
      e = exp_q.pop_front(); g = got_q.pop_front();
      el = exp_last_q.pop_front(); gl = got_last_q.pop_front();
      ec = exp_cnt_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL b2b_block got %h want %h", g, e); end
      checks++;
      if (gl !== el) begin errors++; $display("FAIL b2b_last got %b want %b", gl, el); end
`ifdef SHA_PAD_BLKCNT_EN
      begin
        int gc;
        gc = got_cnt_q.pop_front();
        checks++;
        if (gc !== ec) begin errors++; $display("FAIL b2b_blk_cnt got %0d want %0d", gc, ec); end
      end
`endif
    end
    clear_queues();
  endtask

  task automatic test_reset_mid();
    logic [7:0] msg[$];
    bit ok;
    clear_queues();
    rdy_mode = 0;
    for (int i = 0; i < 20; i++) msg.push_back(8'($urandom));
    send_msg(msg, 1'b0, 1'b0);
    do_reset(1);
    @(negedge clk);
    checks++;
    if (bus.o_msg !== '0 || bus.o_msg_vld !== 1'b0 || bus.o_last_blk !== 1'b0 || bus.o_done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs got vld %b last %b done %b msg_zero %0b want all 0",
               bus.o_msg_vld, bus.o_last_blk, bus.o_done, bus.o_msg === '0);
    end
    checks++;
    if (bus.o_byte_rdy !== 1'b1) begin errors++; $display("FAIL midrst_byte_rdy got %b want 1", bus.o_byte_rdy); end
`ifdef SHA_PAD_BLKCNT_EN
    checks++;
    if (blk_cnt !== 8'd0) begin errors++; $display("FAIL midrst_blk_cnt got %0d want 0", blk_cnt); end
`endif
    @(posedge clk);
    #1;
    clear_queues();
    msg = '{8'h61, 8'h62, 8'h63};
    send_msg(msg, 1'b0, 1'b1);
    wait_blocks(1, ok);
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL midrst_count got %0d want 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== ABC_BLK || got_last_q[0] !== 1'b1) begin
        errors++; $display("FAIL midrst_block got %h last %b want %h last 1", got_q[0], got_last_q[0], ABC_BLK);
      end
    end
    clear_queues();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset          = 1'b1;
    bus.i_byte     = 8'h00;
    bus.i_byte_vld = 1'b0;
    bus.i_last     = 1'b0;
    test_reset();
    test_abc();
    test_boundaries();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha_msg_padder.md
Name: sha_msg_padder

Overview:
SHA-256 front-end padder.
- Accepts the raw message as a byte stream and builds padded 512-bit blocks: append 0x80, zero fill, then the 64-bit big-endian message bit-length.
- Hands each completed block to message_schdule through a valid/ready handshake.
- It is the writer side of the message_schdule i_msg interface: it produces i_msg and sequences the block hand-off.

Parameters:
- MSG_SIZ, 512, block width in bits; only 512 is supported.
- LEN_W, 64, bit-length counter width (at most 64); the counter is zero-extended into the 64-bit length field.

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, synchronous active-high reset.
- i_byte, input, 8, message byte.
- i_byte_vld, input, 1, i_byte is valid.
- i_last, input, 1, current byte is the final message byte; qualified by i_byte_vld.
- o_byte_rdy, output, 1, padder accepts a byte this cycle.
- o_msg, output, MSG_SIZ, padded block; byte k occupies bits [511-8k -: 8].
- o_msg_vld, output, 1, o_msg holds a complete block.
- o_last_blk, output, 1, final block of the message; valid only with o_msg_vld.
- i_msg_rdy, input, 1, downstream accepts o_msg.
- o_done, output, 1, one-cycle pulse when the final block is accepted.

Behaviour:
- Reset: state FILL, block buffer 0, idx 0, bitlen 0, all flags 0. o_msg=0, o_msg_vld=0, o_last_blk=0, o_done=0, o_byte_rdy=1 in the cycle after reset deasserts.
- Reset mid-operation discards any partial block and any pending pad/length work.
- Byte transfer: occurs when i_byte_vld && o_byte_rdy.
- o_byte_rdy=1 only in FILL; it is a registered state decode.
- FILL:
  - On transfer: buf[idx]=i_byte, idx++, bitlen += 8 (wraps mod 2^LEN_W).
  - Not last, idx reaches 64: go to EMIT.
  - Last, idx<64: go to PAD.
  - Last, idx reaches 64: set pad_pend and go to EMIT.
- PAD (one cycle):
  - buf[idx]=0x80, idx++. Remaining bytes are already 0.
  - New idx <= 56: go to LEN.
  - Otherwise: set len_pend and go to EMIT.
- LEN (one cycle): buf bytes 56..63 = zero-extended bitlen, big-endian. Set final, go to EMIT.
- EMIT:
  - o_msg_vld=1, o_last_blk=final. o_msg stays stable until i_msg_rdy.
  - On i_msg_rdy: buf=0, idx=0.
  - If final: o_done=1 next cycle, bitlen=0, flags cleared, go to FILL.
  - Else if pad_pend: clear it, go to PAD.
  - Else if len_pend: clear it, go to LEN.
  - Else: go to FILL.
- Latency for a short message: last byte accepted at cycle n, PAD at n+1, LEN at n+2, o_msg_vld at n+3.
- Throughput: one byte/cycle in FILL; no bytes are accepted during PAD, LEN or EMIT.
- Empty messages are not supported: i_last always accompanies a real byte.
- i_last without i_byte_vld is ignored.
- i_msg_rdy outside EMIT is ignored.
- bitlen wraps silently at 2^LEN_W.

Optional Feature:
SHA_PAD_BLKCNT_EN:
- Defined: adds output port o_blk_cnt [7:0] = index of the block currently presented, 0 for the first block of a message.
  - Increments on each accepted non-final block.
  - Cleared on final-block acceptance and on reset; saturates at 255.
- Undefined: no port and no counter logic.

Test Plan:
1. "abc" (0x61,0x62,0x63, i_last on 0x63), i_msg_rdy=1:
   - o_msg = 512'h616263800...0018, o_last_blk=1.
   - o_msg_vld exactly 3 cycles after the last byte.
   - o_done pulses one cycle after acceptance.
2. 55 bytes of 0x61: a single block.
   - Byte 55 = 0x80, length field 64'h1B8, o_last_blk=1.
3. 56 bytes of 0x61: two blocks.
   - Block 0: byte 56 = 0x80, rest 0, o_last_blk=0.
   - Block 1: all zero except length 64'h1C0, o_last_blk=1.
4. 64 bytes of 0x61: two blocks.
   - Block 0: 64×0x61, o_last_blk=0.
   - Block 1: byte 0 = 0x80, length 64'h200, o_last_blk=1.
5. Backpressure: hold i_msg_rdy=0 for 10 cycles during EMIT.
   - o_msg and o_msg_vld stay constant; o_byte_rdy=0; no byte is lost when i_msg_rdy rises.
6. Reset for 1 cycle after 20 bytes, then send "abc".
   - All outputs read 0 after reset; the next block exactly matches scenario 1.
   - With SHA_PAD_BLKCNT_EN, o_blk_cnt=0.
